// File: rtl/intxn_ctrl_multi_pkg.sv
// rtl/intxn_ctrl_multi_pkg.sv - shared types and light codes for the multi-phase intersection controller
// Purpose: FSM state encoding and the per-phase {red,yellow,green} light codes.
// Ports:   none (package).
package intxn_ctrl_multi_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR    = 3'd0,
      ST_MAIN_GRN = 3'd1,
      ST_MAIN_YEL = 3'd2,
      ST_SIDE_GRN = 3'd3,
      ST_SIDE_YEL = 3'd4
   } state_t;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

endpackage

// File: rtl/intxn_tick_gen.sv
// rtl/intxn_tick_gen.sv - prescaler producing a one-clock tick every TICK_DIV clocks
// Purpose: divides the system clock down to the controller's timing tick.
// Ports:   clock  in  system clock
//          reset  in  asynchronous active-high reset
//          tick   out one-clock pulse when the prescaler wraps
module intxn_tick_gen #(
   parameter int TICK_DIV = 1
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] pcnt;

   // With TICK_DIV=1 the counter sits at 0 and every clock is a tick.
   assign tick = (pcnt == PW'(TICK_DIV - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pcnt <= '0;
      else if (tick)
         pcnt <= '0;
      else
         pcnt <= pcnt + 1'b1;
   end

endmodule

// File: rtl/intxn_ctrl_multi.sv
// rtl/intxn_ctrl_multi.sv - round-robin multi-approach intersection controller resting on main green
// Purpose: rests green on phase 0, serves side phases 1..NUM_PHASES-1 one per main
//          cycle in round-robin order, with yellow and all-red clearance between phases.
// Ports:   clock         in   system clock
//          reset         in   asynchronous active-high reset
//          car_detected  in   per-phase request level (bit 0 ignored)
//          lights_out    out  phase p at [3p+2:3p] = {red,yellow,green}
//          active_phase  out  phase owning green/yellow, 0 at rest
//          pending       out  latched unserved side requests (bit 0 always 0)
module intxn_ctrl_multi
   import intxn_ctrl_multi_pkg::*;
#(
   parameter int NUM_PHASES = 3,
   parameter int PHASE_W    = 2,
   parameter int TICK_DIV   = 1,
   parameter int TW         = 8,
   parameter int MIN_GREEN  = 4,
   parameter int SIDE_GREEN = 3,
   parameter int YELLOW     = 2,
   parameter int ALL_RED    = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_PHASES-1:0]   car_detected,
   output logic [3*NUM_PHASES-1:0] lights_out,
   output logic [PHASE_W-1:0]      active_phase,
   output logic [NUM_PHASES-1:0]   pending
);

   localparam logic [NUM_PHASES-1:0] SIDE_MASK = {{(NUM_PHASES-1){1'b1}}, 1'b0};

   state_t                    state, state_nx;
   logic [TW-1:0]             cnt;
   logic [PHASE_W-1:0]        nxt, rr, winner;
   logic [NUM_PHASES-1:0]     pend, req;
   logic                      tick, done, side_entry;
   logic [3*NUM_PHASES-1:0]   lights_d;
   logic [PHASE_W-1:0]        active_d;

   intxn_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   function automatic logic [TW-1:0] dur_m1(input state_t s);
      case (s)
         ST_MAIN_GRN: dur_m1 = TW'(MIN_GREEN - 1);
         ST_SIDE_GRN: dur_m1 = TW'(SIDE_GREEN - 1);
         ST_MAIN_YEL,
         ST_SIDE_YEL: dur_m1 = TW'(YELLOW - 1);
         default:     dur_m1 = TW'(ALL_RED - 1);
      endcase
   endfunction

   assign req        = car_detected & SIDE_MASK;
   assign done       = tick && (cnt == '0);
   assign side_entry = (state == ST_CLEAR) && (state_nx == ST_SIDE_GRN);

   // First pending side phase at or after rr, wrapping back to 1. Scanning from
   // the far end lets the nearest candidate win by being assigned last.
   always_comb begin
      int k;
      winner = rr;
      for (int i = NUM_PHASES - 2; i >= 0; i--) begin
         k = ((int'(rr) - 1 + i) % (NUM_PHASES - 1)) + 1;
         if (pend[k])
            winner = PHASE_W'(k);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= ST_CLEAR;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_CLEAR:    if (done) state_nx = (nxt == '0) ? ST_MAIN_GRN : ST_SIDE_GRN;
         ST_MAIN_GRN: if (done && (|pend)) state_nx = ST_MAIN_YEL;
         ST_MAIN_YEL: if (done) state_nx = ST_CLEAR;
         ST_SIDE_GRN: if (done) state_nx = ST_SIDE_YEL;
         ST_SIDE_YEL: if (done) state_nx = ST_CLEAR;
         default:     state_nx = ST_CLEAR;
      endcase
   end

   // Interval counter, next-phase selector, rr pointer and request latches.
   // Reset counts as entry into CLEAR, so the counter starts at ALL_RED-1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt  <= TW'(ALL_RED - 1);
         nxt  <= '0;
         rr   <= PHASE_W'(1);
         pend <= '0;
      end else begin
         if (state_nx != state)
            cnt <= dur_m1(state_nx);
         else if (tick && (cnt != '0))
            cnt <= cnt - 1'b1;

         if ((state == ST_MAIN_YEL) && done)
            nxt <= winner;
         else if ((state == ST_SIDE_YEL) && done)
            nxt <= '0;

         if (side_entry)
            rr <= (nxt == PHASE_W'(NUM_PHASES - 1)) ? PHASE_W'(1) : nxt + 1'b1;

         // The phase being served does not re-latch its own car.
         for (int p = 1; p < NUM_PHASES; p++) begin
            if (side_entry && (nxt == PHASE_W'(p)))
               pend[p] <= 1'b0;
            else if (req[p] && !(((state == ST_SIDE_GRN) || (state == ST_SIDE_YEL))
                                 && (nxt == PHASE_W'(p))))
               pend[p] <= 1'b1;
         end
      end
   end

   always_comb begin
      lights_d = {NUM_PHASES{LT_RED}};
      active_d = '0;
      case (state)
         ST_MAIN_GRN: lights_d[2:0] = LT_GRN;
         ST_MAIN_YEL: lights_d[2:0] = LT_YEL;
         ST_SIDE_GRN: begin
            lights_d[3*int'(nxt) +: 3] = LT_GRN;
            active_d = nxt;
         end
         ST_SIDE_YEL: begin
            lights_d[3*int'(nxt) +: 3] = LT_YEL;
            active_d = nxt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lights_out   <= {NUM_PHASES{LT_RED}};
         active_phase <= '0;
         pending      <= '0;
      end else begin
         lights_out   <= lights_d;
         active_phase <= active_d;
         pending      <= pend;
      end
   end

endmodule

// File: tb/tb_intxn_ctrl_multi.sv
// tb/tb_intxn_ctrl_multi.sv - directed self-checking bench for intxn_ctrl_multi
module tb_intxn_ctrl_multi;

   localparam logic [8:0] RED = 9'b100_100_100;
   localparam logic [8:0] MG  = 9'b100_100_001;
   localparam logic [8:0] MY  = 9'b100_100_010;
   localparam logic [8:0] P1G = 9'b100_001_100;
   localparam logic [8:0] P1Y = 9'b100_010_100;
   localparam logic [8:0] P2G = 9'b001_100_100;
   localparam logic [8:0] P2Y = 9'b010_100_100;

   logic       clock;
   logic       reset, rst4;
   logic [2:0] car, car4;
   logic [8:0] lights, lights4;
   logic [1:0] active, active4;
   logic [2:0] pend, pend4;

   int tests = 0;
   int fails = 0;
   int n;

   intxn_ctrl_multi dut (
      .clock        (clock),
      .reset        (reset),
      .car_detected (car),
      .lights_out   (lights),
      .active_phase (active),
      .pending      (pend)
   );

   intxn_ctrl_multi #(.TICK_DIV(4)) dut4 (
      .clock        (clock),
      .reset        (rst4),
      .car_detected (car4),
      .lights_out   (lights4),
      .active_phase (active4),
      .pending      (pend4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic bit inv_ok(input logic [8:0] l);
      int nonred;
      bit ok;
      logic [2:0] f;
      nonred = 0;
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         f = l[3*i +: 3];
         if (!$onehot(f)) ok = 1'b0;
         if (f !== 3'b100) nonred++;
      end
      return ok && (nonred <= 1);
   endfunction

   always @(negedge clock) begin
      tests++;
      assert (inv_ok(lights) && inv_ok(lights4)) else begin
         fails++;
         $error("FAIL invariant: lights=%b lights4=%b required one-hot fields, <=1 non-red", lights, lights4);
      end
   end

   task automatic chk(input logic [8:0] el, input logic [1:0] ea, input logic [2:0] ep, input string tag);
      tests++;
      assert (lights === el) else begin
         fails++;
         $error("FAIL %s lights: got %b expected %b", tag, lights, el);
      end
      tests++;
      assert (active === ea) else begin
         fails++;
         $error("FAIL %s active_phase: got %0d expected %0d", tag, active, ea);
      end
      tests++;
      assert (pend === ep) else begin
         fails++;
         $error("FAIL %s pending: got %b expected %b", tag, pend, ep);
      end
   endtask

   task automatic step(input int cnt, input logic [8:0] el, input logic [1:0] ea,
                       input logic [2:0] ep, input string tag);
      for (int i = 0; i < cnt; i++) begin
         @(posedge clock); #1;
         chk(el, ea, ep, tag);
      end
   endtask

   task automatic count_run(input logic [8:0] val, output int len);
      len = 0;
      while ((lights4 === val) && (len < 200)) begin
         len++;
         @(posedge clock); #1;
      end
   endtask

   task automatic chk_len(input int got, input int exp, input string tag);
      tests++;
      assert (got == exp) else begin
         fails++;
         $error("FAIL %s run length: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b1; rst4 = 1'b1; car = '0; car4 = '0;
      #1;
      chk(RED, 2'd0, 3'b000, "reset_state");
      repeat (3) @(posedge clock);
      #1; reset = 1'b0;

      // Test 1: one all-red clock, then main green held with no requests.
      step(1, RED, 2'd0, 3'b000, "t1_clear");
      step(50, MG, 2'd0, 3'b000, "t1_main_hold");

      // Test 2: single phase-1 pulse.
      car = 3'b010;
      step(1, MG, 2'd0, 3'b000, "t2_latch");
      car = 3'b000;
      step(1, MG, 2'd0, 3'b010, "t2_pend");
      step(2, MY, 2'd0, 3'b010, "t2_main_yel");
      step(1, RED, 2'd0, 3'b010, "t2_allred1");
      step(3, P1G, 2'd1, 3'b000, "t2_p1_grn");
      step(2, P1Y, 2'd1, 3'b000, "t2_p1_yel");
      step(1, RED, 2'd0, 3'b000, "t2_allred2");
      step(1, MG, 2'd0, 3'b000, "t2_main_back");

      // Test 4: request right after main green entry waits out MIN_GREEN.
      car = 3'b010;
      step(1, MG, 2'd0, 3'b000, "t4_latch");
      car = 3'b000;
      step(2, MG, 2'd0, 3'b010, "t4_min_green");
      step(2, MY, 2'd0, 3'b010, "t4_main_yel");
      step(1, RED, 2'd0, 3'b010, "t4_allred");
      // A car at the phase being served is not latched.
      car = 3'b010;
      step(1, P1G, 2'd1, 3'b000, "t4_serving_car");
      car = 3'b000;
      step(1, P1G, 2'd1, 3'b000, "t4_no_relatch");

      // Test 5: reset during side green aborts immediately.
      reset = 1'b1;
      #1;
      chk(RED, 2'd0, 3'b000, "t5_async_reset");
      repeat (3) @(posedge clock);
      #1; reset = 1'b0;
      step(1, RED, 2'd0, 3'b000, "t5_clear");
      step(1, MG, 2'd0, 3'b000, "t5_main");

      // Test 3: simultaneous requests served in rr order, phase 1 first.
      car = 3'b110;
      step(1, MG, 2'd0, 3'b000, "t3_latch");
      car = 3'b000;
      step(2, MG, 2'd0, 3'b110, "t3_main");
      step(2, MY, 2'd0, 3'b110, "t3_main_yel");
      step(1, RED, 2'd0, 3'b110, "t3_allred1");
      step(3, P1G, 2'd1, 3'b100, "t3_p1_grn");
      step(2, P1Y, 2'd1, 3'b100, "t3_p1_yel");
      step(1, RED, 2'd0, 3'b100, "t3_allred2");
      step(4, MG, 2'd0, 3'b100, "t3_main_between");
      step(2, MY, 2'd0, 3'b100, "t3_main_yel2");
      step(1, RED, 2'd0, 3'b100, "t3_allred3");
      step(3, P2G, 2'd2, 3'b000, "t3_p2_grn");
      step(2, P2Y, 2'd2, 3'b000, "t3_p2_yel");
      step(1, RED, 2'd0, 3'b000, "t3_allred4");
      step(1, MG, 2'd0, 3'b000, "t3_main_back");
      car = 3'b110;
      step(1, MG, 2'd0, 3'b000, "t3b_latch");
      car = 3'b000;
      step(2, MG, 2'd0, 3'b110, "t3b_main");
      step(2, MY, 2'd0, 3'b110, "t3b_main_yel");
      step(1, RED, 2'd0, 3'b110, "t3b_allred");
      step(1, P1G, 2'd1, 3'b100, "t3b_p1_first");

      // Test 6: TICK_DIV=4 scales every interval by four.
      rst4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         tests++;
         assert (lights4 === RED) else begin
            fails++;
            $error("FAIL t6_clear lights4: got %b expected %b", lights4, RED);
         end
      end
      @(posedge clock); #1;
      car4 = 3'b010;
      count_run(MG, n);  chk_len(n, 16, "t6_main_grn");
      car4 = 3'b000;
      count_run(MY, n);  chk_len(n, 8, "t6_main_yel");
      count_run(RED, n); chk_len(n, 4, "t6_allred1");
      count_run(P1G, n); chk_len(n, 12, "t6_p1_grn");
      count_run(P1Y, n); chk_len(n, 8, "t6_p1_yel");
      count_run(RED, n); chk_len(n, 4, "t6_allred2");
      tests++;
      assert (lights4 === MG) else begin
         fails++;
         $error("FAIL t6_main_back lights4: got %b expected %b", lights4, MG);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
